// File: rtl/instr_fetch.sv
// RV32I instruction fetch: owns the fetch PC, keeps up to BUF_DEPTH memory requests in flight and
// feeds the IF/ID register from a small prefetch buffer. Define MISALIGN_CHK_EN to add instr_misalign.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_sel,
    input  logic [31:0] pc_target,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_vld
`ifdef MISALIGN_CHK_EN
    ,
    output logic        instr_misalign
`endif
);

    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CNT_W1 = CNT_W + 1;
    localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
    localparam logic [CNT_W:0] DEPTH_LIMIT = CNT_W1'(BUF_DEPTH);

    // Memory handshake: a request transfers on the cycle imem_req && imem_gnt are both high;
    // imem_req is never withdrawn by waiting on imem_gnt, and each transfer yields exactly one
    // imem_rvalid pulse, in order, at least one cycle later.

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] buf_cnt_q, buf_cnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      buf_instr_q [BUF_DEPTH];
    logic [31:0]      buf_pc_q    [BUF_DEPTH];

    logic [31:0]      aligned_target;
    logic [CNT_W:0]   inflight;
    logic             misalign_hold;
    logic             gnt_fire;
    logic             rsp_keep;
    logic             advance;
    logic             pop;
    logic             bypass;
    logic             push;
    logic             ifid_bubble;

    assign aligned_target = {pc_target[31:2], 2'b00};

`ifdef MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (pc_sel) begin
            misalign_q <= |pc_target[1:0];
        end
    end

    assign misalign_hold  = misalign_q;
    assign instr_misalign = misalign_q;
`else
    logic unused_target_lsb;
    assign unused_target_lsb = ^pc_target[1:0];
    assign misalign_hold     = 1'b0;
`endif

    // Credits cover both in-flight requests (including ones to be dropped) and buffered words,
    // so the buffer can never overflow.
    assign inflight  = {1'b0, outstanding_q} + {1'b0, buf_cnt_q};
    assign imem_req  = rst_n && !pc_sel && !misalign_hold && (inflight < DEPTH_LIMIT);
    assign imem_addr = fetch_pc_q;
    assign gnt_fire  = imem_req && imem_gnt;

    assign rsp_keep    = imem_rvalid && (drop_q == '0);
    assign advance     = !pc_sel && !flush && !stall && !misalign_hold;
    assign pop         = advance && (buf_cnt_q != '0);
    assign bypass      = advance && (buf_cnt_q == '0) && rsp_keep;
    assign push        = rsp_keep && !bypass && !pc_sel;
    assign ifid_bubble = pc_sel || flush || misalign_hold || (!stall && !pop && !bypass);

    always_comb begin
        outstanding_d = outstanding_q;
        if (gnt_fire && !imem_rvalid) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!gnt_fire && imem_rvalid) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        buf_cnt_d  = buf_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (pc_sel) begin
            // Every response still owed after this edge belongs to the old path.
            fetch_pc_d = aligned_target;
            resp_pc_d  = aligned_target;
            drop_d     = outstanding_d;
            buf_cnt_d  = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (gnt_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                buf_cnt_d = buf_cnt_q + CNT_W'(1);
            end else if (!push && pop) begin
                buf_cnt_d = buf_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            buf_cnt_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            buf_cnt_q     <= buf_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

    // IF/ID: a bubble keeps the old pc so downstream debug still sees where the stream stood.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr     <= NOP_INSTR;
            pc        <= RESET_PC;
            instr_vld <= 1'b0;
        end else if (ifid_bubble) begin
            instr     <= NOP_INSTR;
            instr_vld <= 1'b0;
        end else if (pop) begin
            instr     <= buf_instr_q[rd_ptr_q];
            pc        <= buf_pc_q[rd_ptr_q];
            instr_vld <= 1'b1;
        end else if (bypass) begin
            instr     <= imem_rdata;
            pc        <= resp_pc_q;
            instr_vld <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for the steady stream, hand sequences for redirects,
// grant starvation, mid-stream reset and (with MISALIGN_CHK_EN) the misalignment flag.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_sel = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_vld;
`ifdef MISALIGN_CHK_EN
    logic        instr_misalign;
`endif

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_sel     (pc_sel),
        .pc_target  (pc_target),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc         (pc),
        .instr_vld  (instr_vld)
`ifdef MISALIGN_CHK_EN
        ,
        .instr_misalign(instr_misalign)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    // memory model: returns the request address as data, mem_lat cycles after the grant
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          mem_lat = 1;
    int          cyc = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        sel;
        logic [31:0] target;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_vld;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] t,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.stall = s; v.flush = f; v.sel = r; v.target = t;
        v.exp_req = er; v.exp_addr = ea; v.exp_vld = ev; v.exp_pc = ep; v.exp_instr = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1 (inputs already set); returns at the next posedge+1.
    task automatic tick();
        logic        fire;
        logic [31:0] fire_addr;
        @(negedge clk);
        fire      = imem_req && imem_gnt;
        fire_addr = imem_addr;
        @(posedge clk);
        cyc++;
        #1;
        if (imem_rvalid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (fire) begin
            mem_addr_q.push_back(fire_addr);
            mem_due_q.push_back(cyc - 1 + mem_lat);
        end
        imem_rvalid = (mem_addr_q.size() != 0) && (mem_due_q[0] <= cyc);
        imem_rdata  = imem_rvalid ? mem_addr_q[0] : 32'hdead_beef;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        pc_sel      = 1'b0;
        pc_target   = 32'h0;
        stall       = 1'b0;
        flush       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_addr_q.delete();
        mem_due_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Walks cycles until every expected pc has appeared; bubbles must carry NOP.
    task automatic run_expect(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            #1;
            if (instr_vld) begin
                chk({tag, " pc"}, pc, exp_q[0]);
                chk({tag, " instr"}, instr, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                chk({tag, " bubble instr"}, instr, NOP);
            end
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout: %0d pcs still expected, want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- test ----------------
    initial begin
        //             stall flush sel target    req addr      vld pc        instr
        vecs[0]  = mk(0, 0, 0, 32'h0,   1, 32'h00, 0, 32'h00, NOP);
        vecs[1]  = mk(0, 0, 0, 32'h0,   1, 32'h04, 0, 32'h00, NOP);
        vecs[2]  = mk(0, 0, 0, 32'h0,   1, 32'h08, 1, 32'h00, 32'h00);
        vecs[3]  = mk(0, 0, 0, 32'h0,   1, 32'h0C, 1, 32'h04, 32'h04);
        vecs[4]  = mk(1, 0, 0, 32'h0,   1, 32'h10, 1, 32'h08, 32'h08);
        vecs[5]  = mk(1, 0, 0, 32'h0,   0, 32'h14, 1, 32'h08, 32'h08);
        vecs[6]  = mk(1, 0, 0, 32'h0,   0, 32'h14, 1, 32'h08, 32'h08);
        vecs[7]  = mk(0, 0, 0, 32'h0,   0, 32'h14, 1, 32'h08, 32'h08);
        vecs[8]  = mk(0, 0, 0, 32'h0,   1, 32'h14, 1, 32'h0C, 32'h0C);
        vecs[9]  = mk(0, 0, 0, 32'h0,   1, 32'h18, 1, 32'h10, 32'h10);
        vecs[10] = mk(0, 0, 0, 32'h0,   1, 32'h1C, 1, 32'h14, 32'h14);
        vecs[11] = mk(0, 1, 0, 32'h0,   1, 32'h20, 1, 32'h18, 32'h18);
        vecs[12] = mk(0, 0, 0, 32'h0,   0, 32'h24, 0, 32'h18, NOP);
        vecs[13] = mk(0, 0, 0, 32'h0,   1, 32'h24, 1, 32'h1C, 32'h1C);
        vecs[14] = mk(0, 0, 0, 32'h0,   1, 32'h28, 1, 32'h20, 32'h20);
        vecs[15] = mk(0, 0, 1, 32'h40,  0, 32'h2C, 1, 32'h24, 32'h24);
        vecs[16] = mk(0, 0, 0, 32'h0,   1, 32'h40, 0, 32'h24, NOP);
        vecs[17] = mk(0, 0, 0, 32'h0,   1, 32'h44, 0, 32'h24, NOP);
        vecs[18] = mk(0, 0, 0, 32'h0,   1, 32'h48, 1, 32'h40, 32'h40);

        // table: fill, stall, flush and a 1-cycle-memory redirect
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < NV; i++) begin
            stall     = vecs[i].stall;
            flush     = vecs[i].flush;
            pc_sel    = vecs[i].sel;
            pc_target = vecs[i].target;
            #1;
            chk($sformatf("vec%0d req", i), imem_req, vecs[i].exp_req);
            chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d vld", i), instr_vld, vecs[i].exp_vld);
            chk($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d instr", i), instr, vecs[i].exp_instr);
            tick();
        end
        stall = 1'b0; flush = 1'b0; pc_sel = 1'b0;

        // redirect with two responses outstanding on a 3-cycle memory
        mem_lat = 3;
        do_reset();
        tick();
        tick();
        pc_sel = 1'b1; pc_target = 32'h100;
        #1;
        chk("seqA redirect req", imem_req, 1'b0);
        tick();
        pc_sel = 1'b0;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        run_expect("seqA", 30);

        // redirect with gnt high, then a second redirect before the drops drain
        mem_lat = 3;
        do_reset();
        tick();
        tick();
        pc_sel = 1'b1; pc_target = 32'h80;
        tick();
        pc_target = 32'h200;
        tick();
        pc_sel = 1'b0;
        exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
        run_expect("seqB", 30);

        // grant starvation, then async reset mid-stream
        mem_lat = 1;
        do_reset();
        imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("nognt%0d req", i), imem_req, 1'b1);
            chk($sformatf("nognt%0d addr", i), imem_addr, 32'h0);
            chk($sformatf("nognt%0d vld", i), instr_vld, 1'b0);
            tick();
        end
        imem_gnt = 1'b1;
        tick();
        tick();
        #1;
        chk("after nognt vld", instr_vld, 1'b1);
        chk("after nognt pc", pc, 32'h0);
        chk("after nognt addr", imem_addr, 32'h8);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst req", imem_req, 1'b0);
        chk("midrst addr", imem_addr, 32'h0);
        chk("midrst instr", instr, NOP);
        chk("midrst pc", pc, 32'h0);
        chk("midrst vld", instr_vld, 1'b0);

`ifdef MISALIGN_CHK_EN
        // misaligned redirect parks fetch until an aligned redirect
        mem_lat = 1;
        do_reset();
        #1;
        chk("mis reset flag", instr_misalign, 1'b0);
        tick();
        tick();
        tick();
        pc_sel = 1'b1; pc_target = 32'h102;
        tick();
        pc_sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mis%0d flag", i), instr_misalign, 1'b1);
            chk($sformatf("mis%0d req", i), imem_req, 1'b0);
            chk($sformatf("mis%0d vld", i), instr_vld, 1'b0);
            tick();
        end
        pc_sel = 1'b1; pc_target = 32'h104;
        tick();
        pc_sel = 1'b0;
        #1;
        chk("mis clear flag", instr_misalign, 1'b0);
        chk("mis resume req", imem_req, 1'b1);
        chk("mis resume addr", imem_addr, 32'h104);
        tick();
        exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        run_expect("mis", 10);
`endif

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
